// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
// Turns the memory stage's one-cycle data-memory request pulse into a held
// valid/ready request on the data peripheral bus, waits for the response,
// registers read data and error status, and holds a done flag until the
// pipeline acknowledges the result. Also drives the memory-stage stall.
//
// Optional feature (macro DMEM_BUS_TIMEOUT_EN):
//   defined   - an access still pending after TIMEOUT_CYCLES bus cycles
//               (REQ + RESP) is aborted and reported as a bus error.
//   undefined - no counter; the bridge waits indefinitely for the bus.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   req_valid_i           one-cycle request pulse from the memory stage
//   req_wen_i             1 = store, 0 = load
//   req_addr_i            byte address
//   req_wdata_i           lane-formatted store data
//   req_strb_i            byte strobe
//   rsp_ack_i             pipeline accepted the result
//   rsp_done_o            result valid, held until acked
//   rsp_rdata_o           registered raw bus read word (0 for stores/timeouts)
//   rsp_err_o             bus error or timeout, valid with rsp_done_o
//   stall_o               access in flight (combinational on rsp_ack_i)
//   bus_valid_o           bus request valid
//   bus_ready_i           slave accepts request
//   bus_addr_o            word-aligned address
//   bus_wdata_o           write data
//   bus_strb_o            byte strobe
//   bus_we_o              write enable
//   bus_rvalid_i          response valid (reads and write acks)
//   bus_rdata_i           read data
//   bus_err_i             slave error, qualified by bus_rvalid_i
// -----------------------------------------------------------------------------
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_strb_i,
    input  logic        rsp_ack_i,
    output logic        rsp_done_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        stall_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_strb_o,
    output logic        bus_we_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    localparam int unsigned ST_W = 2;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 4;

    localparam logic [ST_W-1:0] S_IDLE = 2'd0;
    localparam logic [ST_W-1:0] S_REQ  = 2'd1;
    localparam logic [ST_W-1:0] S_RESP = 2'd2;
    localparam logic [ST_W-1:0] S_DONE = 2'd3;

    // Elaboration-time parameter sanity check
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
        (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_param_check
        $error("dmem_bus_bridge: illegal TIMEOUT_CYCLES/CNT_W combination");
    end

    logic [ST_W-1:0] state_q, state_d;
    logic [DW-1:0]   addr_q,  addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   strb_q,  strb_d;
    logic            we_q,    we_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q,   err_d;
    logic            done_q,  done_d;

`ifdef DMEM_BUS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef DMEM_BUS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef DMEM_BUS_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        we_d    = we_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = done_q;
`ifdef DMEM_BUS_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i & ~32'h3;
                    wdata_d = req_wdata_i;
                    strb_d  = req_strb_i;
                    we_d    = req_wen_i;
                    valid_d = 1'b1;
                    state_d = S_REQ;
`ifdef DMEM_BUS_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_REQ: begin
                if (bus_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_rvalid_i) begin
                    rdata_d = we_q ? '0 : bus_rdata_i;
                    err_d   = bus_err_i;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // A request pulse here is dropped; the stage re-issues after advancing
                if (rsp_ack_i) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef DMEM_BUS_TIMEOUT_EN
        // Abort on the cycle the counter would reach TIMEOUT_CYCLES, unless the
        // response completes on that same cycle
        if (state_q == S_REQ || state_q == S_RESP) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) &&
                !(state_q == S_RESP && bus_rvalid_i)) begin
                valid_d = 1'b0;
                rdata_d = '0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
        end
`endif
    end

    assign rsp_done_o  = done_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign bus_valid_o = valid_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign bus_strb_o  = strb_q;
    assign bus_we_o    = we_q;

    // Stall releases in the same cycle the pipeline acks the result
    assign stall_o = (state_q == S_REQ) || (state_q == S_RESP) ||
                     ((state_q == S_DONE) && !rsp_ack_i);

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
// Directed bench for dmem_bus_bridge. Stimulus pushes the expected response of
// each completing access into a queue; a monitor pops and compares whenever
// rsp_done_o rises. Cycle-exact bus-side checks are made inline.
// -----------------------------------------------------------------------------
module tb_dmem_bus_bridge;

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_wen_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [3:0]  req_strb_i = '0;
    logic        rsp_ack_i = 1'b0;
    logic        rsp_done_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        stall_o;
    logic        bus_valid_o;
    logic        bus_ready_i = 1'b0;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_strb_o;
    logic        bus_we_o;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_err_i = 1'b0;

    int   tests_run = 0;
    int   tests_failed = 0;
    int   hs_count = 0;
    exp_t exp_q[$];

    dmem_bus_bridge #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_wen_i    (req_wen_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_strb_i   (req_strb_i),
        .rsp_ack_i    (rsp_ack_i),
        .rsp_done_o   (rsp_done_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .stall_o      (stall_o),
        .bus_valid_o  (bus_valid_o),
        .bus_ready_i  (bus_ready_i),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_strb_o   (bus_strb_o),
        .bus_we_o     (bus_we_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: compare each rising rsp_done_o against the scoreboard, count handshakes
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bus_valid_o && bus_ready_i) hs_count++;
            if (rsp_done_o && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(rsp_done_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rdata", rsp_rdata_o, e.rdata);
                    check("sb_err", 32'(rsp_err_o), 32'(e.err));
                end
            end
            prev_done = rsp_done_o;
        end
    end

    // Zero-wait access, acked on the done cycle; returns in IDLE one cycle after ack
    task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.rdata = wen ? 32'd0 : rdata;
        e.err   = err;
        exp_q.push_back(e);
        req_valid_i = 1'b1; req_wen_i = wen; req_addr_i = addr;
        req_wdata_i = wdata; req_strb_i = strb;
        tick();
        req_valid_i = 1'b0;
        check("acc_bus_valid_c1", 32'(bus_valid_o), 32'd1);
        check("acc_done_low_c1", 32'(rsp_done_o), 32'd0);
        check("acc_bus_addr", bus_addr_o, addr & ~32'h3);
        bus_ready_i = 1'b1;
        tick();
        bus_ready_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = rdata; bus_err_i = err;
        tick();
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        check("acc_done_c3", 32'(rsp_done_o), 32'd1);
        check("acc_stall_done", 32'(stall_o), 32'd1);
        rsp_ack_i = 1'b1;
        #1;
        check("acc_stall_ack", 32'(stall_o), 32'd0);
        tick();
        rsp_ack_i = 1'b0;
        check("acc_done_cleared", 32'(rsp_done_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_before;
        int vcycles;

        // Reset state
        tick(); tick();
        rst_i = 1'b0;
        check("rst_done", 32'(rsp_done_o), 32'd0);
        check("rst_bus_valid", 32'(bus_valid_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_addr", bus_addr_o, 32'd0);
        tick();

        // Zero-wait load
        access(1'b0, 32'h1000_0006, 32'd0, 4'hC, 32'hDEAD_BEEF, 1'b0);
        check("load_rdata_kept", rsp_rdata_o, 32'hDEAD_BEEF);
        check("load_err_clear", 32'(rsp_err_o), 32'd0);
        check("load_stall_idle", 32'(stall_o), 32'd0);
        tick();

        // Stalled store: ready low for 4 cycles, then high
        exp_q.push_back('{rdata: 32'd0, err: 1'b0});
        req_valid_i = 1'b1; req_wen_i = 1'b1; req_addr_i = 32'h2000_0011;
        req_wdata_i = 32'h0000_AB00; req_strb_i = 4'h2;
        tick();
        req_valid_i = 1'b0; req_wdata_i = 32'hFFFF_FFFF; req_strb_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("st_valid_%0d", i), 32'(bus_valid_o), 32'd1);
            check($sformatf("st_addr_%0d", i), bus_addr_o, 32'h2000_0010);
            check($sformatf("st_wdata_%0d", i), bus_wdata_o, 32'h0000_AB00);
            check($sformatf("st_strb_we_%0d", i), {27'd0, bus_we_o, bus_strb_o}, 32'h12);
            if (i == 4) bus_ready_i = 1'b1;
            tick();
        end
        bus_ready_i = 1'b0;
        check("st_valid_dropped", 32'(bus_valid_o), 32'd0);
        tick();
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        tick();
        bus_rvalid_i = 1'b0;
        check("st_done", 32'(rsp_done_o), 32'd1);
        rsp_ack_i = 1'b1;
        tick();
        rsp_ack_i = 1'b0;

        // Bus error load with extra pulses in RESP/DONE
        hs_before = hs_count;
        exp_q.push_back('{rdata: 32'h0BAD_0BAD, err: 1'b1});
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h3000_0008; req_strb_i = 4'hF;
        tick();
        req_valid_i = 1'b0; bus_ready_i = 1'b1;
        tick();
        bus_ready_i = 1'b0; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0BAD_0BAD; bus_err_i = 1'b1;
        tick();
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        check("err_done_held", 32'(rsp_done_o), 32'd1);
        check("err_flag", 32'(rsp_err_o), 32'd1);
        check("err_no_reissue_done", 32'(bus_valid_o), 32'd0);
        rsp_ack_i = 1'b1; req_valid_i = 1'b1;
        tick();
        rsp_ack_i = 1'b0; req_valid_i = 1'b0;
        tick();
        check("err_no_reissue_idle", 32'(bus_valid_o), 32'd0);
        check("err_stall_idle", 32'(stall_o), 32'd0);
        check("err_hs_count", 32'(hs_count - hs_before), 32'd1);

`ifdef DMEM_BUS_TIMEOUT_EN
        // Timeout with ready tied low
        exp_q.push_back('{rdata: 32'd0, err: 1'b1});
        req_valid_i = 1'b1; req_wen_i = 1'b0; req_addr_i = 32'h5000_0000; req_strb_i = 4'hF;
        tick();
        req_valid_i = 1'b0;
        vcycles = 0;
        while (bus_valid_o && vcycles < 20) begin
            vcycles++;
            tick();
        end
        check("to_valid_cycles", 32'(vcycles), 32'd8);
        check("to_done", 32'(rsp_done_o), 32'd1);
        check("to_err", 32'(rsp_err_o), 32'd1);
        check("to_rdata", rsp_rdata_o, 32'd0);
        rsp_ack_i = 1'b1;
        tick();
        rsp_ack_i = 1'b0;
        bus_rvalid_i = 1'b1; bus_err_i = 1'b1; bus_rdata_i = 32'hCAFE_F00D;
        tick();
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        check("to_late_done", 32'(rsp_done_o), 32'd0);
        check("to_late_stall", 32'(stall_o), 32'd0);
        tick();
`else
        vcycles = 0;
`endif

        // Reset while in RESP abandons the access
        req_valid_i = 1'b1; req_wen_i = 1'b1; req_addr_i = 32'h4000_0004;
        req_wdata_i = 32'h5555_AAAA; req_strb_i = 4'hF;
        tick();
        req_valid_i = 1'b0; bus_ready_i = 1'b1;
        tick();
        bus_ready_i = 1'b0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_done", 32'(rsp_done_o), 32'd0);
        check("mrst_rdata", rsp_rdata_o, 32'd0);
        check("mrst_err", 32'(rsp_err_o), 32'd0);
        check("mrst_stall", 32'(stall_o), 32'd0);
        check("mrst_bus_valid", 32'(bus_valid_o), 32'd0);
        check("mrst_bus_addr", bus_addr_o, 32'd0);
        check("mrst_bus_wdata", bus_wdata_o, 32'd0);
        check("mrst_strb_we", {27'd0, bus_we_o, bus_strb_o}, 32'd0);
        tick();
        access(1'b0, 32'h4000_0008, 32'd0, 4'hF, 32'h0102_0304, 1'b0);

        // Back-to-back: second pulse in the cycle right after the ack
        access(1'b1, 32'h6000_0000, 32'hA5A5_5A5A, 4'hF, 32'h7777_7777, 1'b0);
        access(1'b0, 32'h6000_0004, 32'd0, 4'h3, 32'h89AB_CDEF, 1'b0);
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
